pool_window_collector: RTL
==========================

Name: pool_window_collector

Overview:
- Downstream consumer of the mid-layer channel buffer.
- Takes one 2x2 window per channel per valid_in beat, max-pools each window (signed), and queues the pooled pixel in a small FIFO.
- Re-serialises pooled pixels as a raster stream of CH-channel words with a valid/ready handshake and row/column tags, for the next layer's input buffer.
- Default frame is 34x26 in, 17x13 = 221 pooled pixels out.

Parameters:
- CH, 32, channel count.
- DW, 32, data width per element (two's complement).
- OUT_W, 13, pooled columns per row.
- OUT_H, 17, pooled rows per frame.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  window beat valid; no ready exists upstream.
- win_in  input  CH*4*DW  flattened windows. Channel c occupies bits [c*4*DW +: 4*DW]. Within a channel, element k = 2*r + s (window[r][s]) is at [k*DW +: DW].
- out_ready  input  1  downstream accepts the current beat.
- valid_out  output  1  FIFO head is valid.
- data_out  output  CH*DW  pooled word; channel c at [c*DW +: DW].
- out_row  output  $clog2(OUT_H)  row index of the current head beat.
- out_col  output  $clog2(OUT_W)  column index of the current head beat.
- frame_last  output  1  current head beat is the last pixel of the frame.
- frame_done  output  1  one-cycle pulse after the last beat is handshaken.
- overflow  output  1  sticky: a window was dropped.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, row/col counters 0, pool stage invalid. Reset mid-frame discards all queued data; the next beat is row 0, col 0.
- Pool stage: at an edge where valid_in=1, pool_reg[c] <= signed max of the 4 elements of channel c, and pool_v <= 1. Otherwise pool_v <= 0. Ties may pick any element since the values are equal.
- Push: at an edge where pool_v=1, pool_reg is written to the FIFO tail.
- Latency: valid_in sampled at edge t gives valid_out=1 after edge t+1, if the FIFO was empty. Back-to-back valid_in sustains 1 beat/cycle while out_ready=1.
- FIFO is show-ahead: data_out is the head entry; valid_out = (count != 0).
- Pop: at an edge where valid_out & out_ready.
- Full: a push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the pooled word is dropped, overflow is set to 1, and FIFO contents are unchanged. overflow clears only on reset.
- Empty: out_ready with valid_out=0 is ignored. Counters do not move.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Counters advance on each pop:
  - col increments; at OUT_W-1 it wraps to 0 and row increments.
  - at row OUT_H-1 with col OUT_W-1, both wrap to 0.
  - out_row/out_col always show the head beat's indices. Dropped windows are not counted.
- frame_last = valid_out & (row==OUT_H-1) & (col==OUT_W-1), combinational from the counters.
- frame_done is registered: 1 for exactly the cycle after the pop of a frame_last beat, otherwise 0.
- data_out is held stable while valid_out=1 and out_ready=0.

Test Plan:
- Reset: assert rst_n=0 mid-traffic → all outputs 0 immediately, FIFO empty. After release, the first beat carries row=0, col=0.
- Single window: ch0={5,-3,9,2}, ch1={-1,-7,-2,-8}, all other channels 0, out_ready=1, valid_in at edge t → after edge t+1, valid_out=1, ch0=0x00000009, ch1=0xFFFFFFFF, remaining channels 0. valid_out returns to 0 the cycle after.
- Full frame: 221 consecutive windows with random data, out_ready=1 → exactly 221 beats, each matching the reference max model, with tags in raster order. frame_last is high only on beat 221 (row=16, col=12). frame_done pulses once, one cycle later. The next beat is tagged row=0, col=0. overflow=0.
- Backpressure/overflow: out_ready=0, 6 consecutive windows → 4 entries held, overflow=1 from the 5th push onward. Then out_ready=1 → 4 beats equal to windows 1-4 in order, tags (0,0)..(0,3), then valid_out=0.
- Push at full with pop: fill 4 entries, then assert valid_in and out_ready together continuously for 20 cycles → no drop, overflow stays 0, output order matches input order.

Source files
------------

// File: rtl/pool_window_collector.sv
// Generic show-ahead FIFO.
// Latency: a push is visible at the head one cycle later.
// Backpressure: no internal guarding; the caller must not push when full without a pop, or pop when empty.
module fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         not_empty,
   output logic         full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // Storage carries no reset; validity lives entirely in count.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_dat    = mem[rd_ptr];
   assign not_empty = (count != '0);
   assign full      = (count == (AW+1)'(DEPTH));
endmodule

// Signed 2x2 max-pool per channel, queued and re-serialised as a raster stream with row/col tags.
// Latency: valid_in at edge t shows on valid_out after edge t+1 when the queue is empty.
// Backpressure: out_ready stalls the queue; a pooled word arriving at a full queue with no pop is dropped and overflow sticks.
module pool_window_collector #(
   parameter int CH         = 32,
   parameter int DW         = 32,
   parameter int OUT_W      = 13,
   parameter int OUT_H      = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic [CH*4*DW-1:0]       win_in,
   input  logic                     out_ready,
   output logic                     valid_out,
   output logic [CH*DW-1:0]         data_out,
   output logic [$clog2(OUT_H)-1:0] out_row,
   output logic [$clog2(OUT_W)-1:0] out_col,
   output logic                     frame_last,
   output logic                     frame_done,
   output logic                     overflow
);
   localparam int RW = $clog2(OUT_H);
   localparam int CW = $clog2(OUT_W);

   function automatic logic [DW-1:0] max4(input logic [4*DW-1:0] w);
      logic signed [DW-1:0] m;
      logic signed [DW-1:0] e;
      m = w[DW-1:0];
      for (int k = 1; k < 4; k++) begin
         e = w[k*DW +: DW];
         if (e > m) m = e;
      end
      return m;
   endfunction

   logic [CH*DW-1:0] pool_max;
   logic [CH*DW-1:0] pool_reg;
   logic             pool_v;
   logic [CH*DW-1:0] head;
   logic             full;
   logic             pop;
   logic             push;
   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic             at_last;

   for (genvar c = 0; c < CH; c++) begin : g_pool
      assign pool_max[c*DW +: DW] = max4(win_in[c*4*DW +: 4*DW]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pool_reg <= '0;
         pool_v   <= 1'b0;
      end else begin
         pool_v <= valid_in;
         if (valid_in) pool_reg <= pool_max;
      end
   end

   // A same-cycle pop frees the slot, so a full queue still accepts.
   assign pop  = valid_out & out_ready;
   assign push = pool_v & (~full | pop);

   fifo #(.W(CH*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (push),
      .wr_dat    (pool_reg),
      .rd_en     (pop),
      .rd_dat    (head),
      .not_empty (valid_out),
      .full      (full)
   );

   assign data_out   = valid_out ? head : '0;
   assign at_last    = (row == RW'(OUT_H-1)) & (col == CW'(OUT_W-1));
   assign frame_last = valid_out & at_last;
   assign out_row    = row;
   assign out_col    = col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row        <= '0;
         col        <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= pop & frame_last;
         if (pool_v & full & ~pop) overflow <= 1'b1;
         if (pop) begin
            if (col == CW'(OUT_W-1)) begin
               col <= '0;
               row <= (row == RW'(OUT_H-1)) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end
endmodule
